if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction-address width (PC+1 and jump target).
REQ-002 SHALL have parameter SQUASH_SLOTS, default 2, wrong-path captures invalidated after a jump (range 1..3).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr_in  in  32  instruction word from fetch.
REQ-006 SHALL have port pc4_in  in  ADDR_W  PC+1 from fetch.
REQ-007 SHALL have port stall  in  1  hazard hold; stage keeps contents.
REQ-008 SHALL have port flush  in  1  kill stage contents and pending squash.
REQ-009 SHALL have port instr_out  out  32  registered instruction to decode.
REQ-010 SHALL have port pc4_out  out  ADDR_W  registered PC+1.
REQ-011 SHALL have port valid_out  out  1  instr_out is a real, on-path instruction.
REQ-012 SHALL have port jump_ctrl  out  1  redirect strobe to fetch mux control.
REQ-013 SHALL have port jump_addr  out  ADDR_W  redirect target to fetch.

Function
REQ-014 Capture priority per edge SHALL be: flush > stall > squash > normal load.
REQ-015 Flush: instr_out<=NOP (32'h0), pc4_out<=0, valid_out<=0, squash_cnt<=0, jump_done<=0.
REQ-016 Stall (no flush): all registers incl. squash_cnt and jump_done hold; jump_ctrl held low.
REQ-017 Squash (squash_cnt>0, no flush/stall): instr_out<=NOP, valid_out<=0, pc4_out<=pc4_in, squash_cnt decrements.
REQ-018 Normal load: instr_out<=instr_in, pc4_out<=pc4_in, valid_out<=1, jump_done<=0; latency exactly one cycle.
REQ-019 Jump detect: is_jump = valid_out & (instr_out[31:26]==6'b000010 (J) or 6'b000011 (JAL)).
REQ-020 jump_ctrl SHALL be combinational: is_jump & ~jump_done & ~stall & ~flush.
REQ-021 jump_addr SHALL equal instr_out[ADDR_W-1:0] at all times (don't-care when jump_ctrl=0).
REQ-022 On an edge where jump_ctrl=1: jump_done<=1, squash_cnt<=SQUASH_SLOTS (macro-adjusted, REQ-028); that same edge's capture is the first squashed slot only if REQ-028 leaves count>0.
REQ-023 jump_ctrl SHALL pulse at most once per accepted jump instruction, even across stalls.
REQ-024 Jump in instr_out while squash_cnt>0 cannot occur (squashed slots are NOP); no nested redirect.
REQ-025 pc4_out arithmetic SHALL be pass-through, no wrap handling; ADDR_W wrap belongs to fetch.

Reset
REQ-026 While reset=1, independent of clk: instr_out=0, pc4_out=0, valid_out=0, squash_cnt=0, jump_done=0, hence jump_ctrl=0; first edge after deassertion performs a normal load.
REQ-027 Reset asserted mid-squash or mid-stall SHALL abandon it completely.

Configuration
REQ-028 Macro IF_ID_DELAY_SLOT_EN: defined -> squash count loaded is SQUASH_SLOTS-1 (first instruction after jump executes as delay slot, valid_out=1); undefined -> SQUASH_SLOTS, no delay slot.

Structure
REQ-029 Shared package if_id_pkg SHALL hold OPC_J, OPC_JAL, NOP_INSTR (32'h0) and default ADDR_W.
REQ-030 Opcode decode SHALL be a sub-module jump_decoder (instr in, is_jump out); state, counter, and muxing stay in if_id_stage.

Verification
REQ-031 Reset then instr_in=32'h2001_0005, pc4_in=1 -> next edge instr_out=32'h2001_0005, pc4_out=1, valid_out=1, jump_ctrl=0.
REQ-032 Load J instr 32'h0800_0007 -> jump_ctrl=1, jump_addr=7 for one cycle; next 2 captures NOP/valid_out=0 (macro off), 1 capture (macro on).
REQ-033 J instr in stage, stall=1 for 3 cycles -> jump_ctrl=0 throughout, outputs hold; stall drop -> single jump_ctrl pulse.
REQ-034 flush=1 and stall=1 same edge during squash_cnt=1 -> instr_out=0, valid_out=0, squash_cnt=0; next edge normal load.
REQ-035 reset pulse asynchronously between edges with valid J in stage -> valid_out and jump_ctrl drop immediately, no redirect after release.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared constants and types for the IF/ID pipeline register.
// Opcodes follow the MIPS-style J/JAL encoding in instr[31:26].
package if_id_pkg;

  localparam int DEF_ADDR_W = 4;

  localparam logic [5:0]  OPC_J     = 6'b000010;
  localparam logic [5:0]  OPC_JAL   = 6'b000011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    CAP_FLUSH,
    CAP_HOLD,
    CAP_SQUASH,
    CAP_LOAD
  } cap_e;

endpackage

// File: rtl/if_id_jump_decoder.sv
// Opcode decode for unconditional jumps (J, JAL).
// Only the opcode field matters; operand bits are ignored.
module jump_decoder
  import if_id_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_jump
);

  logic [5:0] opc;
  logic       unused_operand;

  assign opc            = instr[31:26];
  assign unused_operand = ^instr[25:0];
  assign is_jump        = (opc == OPC_J) || (opc == OPC_JAL);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with jump redirect and wrong-path squash.
// Define IF_ID_DELAY_SLOT_EN to execute one delay slot after a jump.
module if_id_stage
  import if_id_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int SQUASH_SLOTS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc4_in,
  input  logic              stall,
  input  logic              flush,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc4_out,
  output logic              valid_out,
  output logic              jump_ctrl,
  output logic [ADDR_W-1:0] jump_addr
);

`ifdef IF_ID_DELAY_SLOT_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  // Slots still to squash after the redirect edge itself.
  localparam logic [1:0] SQ_LOAD = 2'(SQUASH_SLOTS - 1);

  logic [1:0] squash_cnt;
  logic       jump_done;
  logic       opc_jump;
  logic       is_jump;
  cap_e       cap;

  jump_decoder u_dec (
    .instr   (instr_out),
    .is_jump (opc_jump)
  );

  assign is_jump   = valid_out & opc_jump;
  assign jump_ctrl = is_jump & ~jump_done & ~stall & ~flush;
  assign jump_addr = instr_out[ADDR_W-1:0];

  always_comb begin
    cap = CAP_LOAD;
    priority case (1'b1)
      flush:             cap = CAP_FLUSH;
      stall:             cap = CAP_HOLD;
      jump_ctrl:         cap = DS_EN ? CAP_LOAD : CAP_SQUASH;
      (squash_cnt != 0): cap = CAP_SQUASH;
      default:           cap = CAP_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_out  <= NOP_INSTR;
      pc4_out    <= '0;
      valid_out  <= 1'b0;
      squash_cnt <= 2'd0;
      jump_done  <= 1'b0;
    end else begin
      unique case (cap)
        CAP_FLUSH: begin
          instr_out  <= NOP_INSTR;
          pc4_out    <= '0;
          valid_out  <= 1'b0;
          squash_cnt <= 2'd0;
          jump_done  <= 1'b0;
        end
        CAP_HOLD: begin
        end
        CAP_SQUASH: begin
          instr_out  <= NOP_INSTR;
          pc4_out    <= pc4_in;
          valid_out  <= 1'b0;
          squash_cnt <= jump_ctrl ? SQ_LOAD : squash_cnt - 2'd1;
          jump_done  <= jump_done | jump_ctrl;
        end
        CAP_LOAD: begin
          instr_out  <= instr_in;
          pc4_out    <= pc4_in;
          valid_out  <= 1'b1;
          squash_cnt <= jump_ctrl ? SQ_LOAD : squash_cnt;
          jump_done  <= jump_ctrl;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed cases plus random
// traffic compared every cycle against a transaction-level model.
module tb_if_id_stage;

  localparam int AW    = 4;
  localparam int SLOTS = 2;
`ifdef IF_ID_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   instr_in = '0;
  logic [AW-1:0] pc4_in = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   instr_out;
  logic [AW-1:0] pc4_out;
  logic          valid_out;
  logic          jump_ctrl;
  logic [AW-1:0] jump_addr;

  int checks = 0;
  int errors = 0;

  if_id_stage #(.ADDR_W(AW), .SQUASH_SLOTS(SLOTS)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr_in  (instr_in),
    .pc4_in    (pc4_in),
    .stall     (stall),
    .flush     (flush),
    .instr_out (instr_out),
    .pc4_out   (pc4_out),
    .valid_out (valid_out),
    .jump_ctrl (jump_ctrl),
    .jump_addr (jump_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit opc_jump(input logic [31:0] w);
    return (w[31:26] == 6'd2) || (w[31:26] == 6'd3);
  endfunction

  // Model: what decode holds, how many wrong-path NOPs are owed,
  // and whether the held jump has already redirected fetch.
  logic [31:0]   m_instr = '0;
  logic [AW-1:0] m_pc = '0;
  bit            m_valid = 1'b0;
  int            m_owed = 0;
  bit            m_fired = 1'b0;

  function automatic bit m_redirect();
    return m_valid && opc_jump(m_instr) && !m_fired
           && !stall && !flush && !reset;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_instr = '0; m_pc = '0; m_valid = 0; m_owed = 0; m_fired = 0;
    end else if (flush) begin
      m_instr = '0; m_pc = '0; m_valid = 0; m_owed = 0; m_fired = 0;
    end else if (!stall) begin
      if (m_redirect()) begin
        m_owed  = DS ? SLOTS - 1 : SLOTS;
        m_fired = 1;
        if (DS) begin
          m_instr = instr_in; m_valid = 1;
        end else begin
          m_instr = '0; m_valid = 0; m_owed--;
        end
        m_pc = pc4_in;
      end else if (m_owed > 0) begin
        m_instr = '0; m_valid = 0; m_pc = pc4_in; m_owed--;
      end else begin
        m_instr = instr_in; m_valid = 1; m_pc = pc4_in; m_fired = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_instr", instr_out, m_instr);
    chk("cyc_pc4", 32'(pc4_out), 32'(m_pc));
    chk("cyc_valid", 32'(valid_out), 32'(m_valid));
    chk("cyc_jctrl", 32'(jump_ctrl), 32'(m_redirect()));
    chk("cyc_jaddr", 32'(jump_addr), 32'(m_instr[AW-1:0]));
  end

  task automatic drive(input logic [31:0] i, input logic [AW-1:0] p,
                       input logic s, input logic f);
    instr_in = i; pc4_in = p; stall = s; flush = f;
  endtask

  task automatic step(input logic [31:0] i, input logic [AW-1:0] p,
                      input logic s, input logic f);
    drive(i, p, s, f);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_jctrl", 32'(jump_ctrl), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    step(32'h2001_0005, 4'd1, 0, 0);
    chk("ld_instr", instr_out, 32'h2001_0005);
    chk("ld_pc4", 32'(pc4_out), 32'd1);
    chk("ld_valid", 32'(valid_out), 32'd1);
    chk("ld_jctrl", 32'(jump_ctrl), 32'd0);

    step(32'h0800_0007, 4'd2, 0, 0);
    drive(32'h2002_0001, 4'd3, 0, 0);
    #1;
    chk("j_jctrl", 32'(jump_ctrl), 32'd1);
    chk("j_jaddr", 32'(jump_addr), 32'd7);
    step(32'h2002_0001, 4'd3, 0, 0);
    chk("j_after_jctrl", 32'(jump_ctrl), 32'd0);
    chk("j_slot1_valid", 32'(valid_out), 32'(DS));
    step(32'h2003_0002, 4'd4, 0, 0);
    chk("j_slot2_valid", 32'(valid_out), 32'd0);
    chk("j_slot2_instr", instr_out, 32'h0);
    step(32'h2004_0003, 4'd5, 0, 0);
    chk("j_resume_valid", 32'(valid_out), 32'd1);
    chk("j_resume_instr", instr_out, 32'h2004_0003);

    step(32'h0C00_0009, 4'd6, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(32'h2005_0000, 4'd7, 1, 0);
      #1;
      chk("stl_jctrl", 32'(jump_ctrl), 32'd0);
      step(32'h2005_0000, 4'd7, 1, 0);
      chk("stl_instr", instr_out, 32'h0C00_0009);
    end
    drive(32'h2005_0000, 4'd7, 0, 0);
    #1;
    chk("stl_drop_jctrl", 32'(jump_ctrl), 32'd1);
    chk("stl_drop_jaddr", 32'(jump_addr), 32'd9);
    step(32'h2005_0000, 4'd7, 0, 0);
    chk("stl_once_jctrl", 32'(jump_ctrl), 32'd0);

    step(32'h2006_0000, 4'd8, 1, 1);
    chk("fl_instr", instr_out, 32'h0);
    chk("fl_valid", 32'(valid_out), 32'd0);
    chk("fl_pc4", 32'(pc4_out), 32'd0);
    step(32'h2007_0004, 4'd9, 0, 0);
    chk("fl_next_valid", 32'(valid_out), 32'd1);
    chk("fl_next_instr", instr_out, 32'h2007_0004);

    step(32'h0800_000A, 4'd10, 0, 0);
    drive(32'h2008_0000, 4'd11, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(valid_out), 32'd0);
    chk("ar_jctrl", 32'(jump_ctrl), 32'd0);
    chk("ar_instr", instr_out, 32'h0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_after_instr", instr_out, 32'h2008_0000);
    chk("ar_after_jctrl", 32'(jump_ctrl), 32'd0);

    for (int c = 0; c < 600; c++) begin
      logic [31:0] w;
      int sel;
      sel = $urandom_range(0, 7);
      w = $urandom;
      if (sel == 0) w[31:26] = 6'd2;
      else if (sel == 1) w[31:26] = 6'd3;
      drive(w, AW'($urandom), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
